// File: rtl/bus_xfer_sequencer_pkg.sv
// bus_xfer_sequencer_pkg: source encodings, FSM states and source one-hot decode
package bus_xfer_sequencer_pkg;
  localparam int SRC_W = 5;
  localparam int SRC_N = 23;
  localparam logic [SRC_W-1:0] SRC_R0 = 5'd0;
  localparam logic [SRC_W-1:0] SRC_R15 = 5'd15;
  localparam logic [SRC_W-1:0] SRC_HI = 5'd16;
  localparam logic [SRC_W-1:0] SRC_LO = 5'd17;
  localparam logic [SRC_W-1:0] SRC_ZHIGH = 5'd18;
  localparam logic [SRC_W-1:0] SRC_ZLOW = 5'd19;
  localparam logic [SRC_W-1:0] SRC_PC = 5'd20;
  localparam logic [SRC_W-1:0] SRC_MDR = 5'd21;
  localparam logic [SRC_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [SRC_W-1:0] SRC_COUNT = 5'd23;
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_MDR} state_t;
  function automatic logic [SRC_N-1:0] onehot(input logic [SRC_W-1:0] s);
    return s < SRC_COUNT ? SRC_N'(1) << s : '0;
  endfunction
endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// bus_xfer_sequencer_if: command handshake, memory-ready and bus enable signals
interface bus_xfer_sequencer_if #(parameter int DST_W = 24);
  import bus_xfer_sequencer_pkg::*;
  logic cmd_valid, cmd_ready, mdr_valid, busy, err;
  logic [SRC_W-1:0] cmd_src;
  logic [DST_W-1:0] cmd_dst, dst_in;
  logic [SRC_N-1:0] src_out;
  modport master (output cmd_valid, cmd_src, cmd_dst, mdr_valid, input cmd_ready, src_out, dst_in, busy, err);
  modport slave (input cmd_valid, cmd_src, cmd_dst, mdr_valid, output cmd_ready, src_out, dst_in, busy, err);
endinterface

// File: rtl/bus_xfer_sequencer_fifo.sv
// cmd_fifo: synchronous command queue; a pushed entry is never readable in its push cycle
module cmd_fifo #(parameter int DEPTH = 4, parameter int W = 29) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: drains queued bus transfers, driving at most one source per cycle
module bus_xfer_sequencer
  import bus_xfer_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DST_W = 24,
  parameter int MDR_TMO = 15
) (
  input logic clk,
  input logic rst,
  bus_xfer_sequencer_if.slave bus
);
  localparam int CW = $clog2(MDR_TMO + 1);
  state_t state;
  logic full, empty, pop;
  logic [$clog2(DEPTH):0] count;
  logic [SRC_W+DST_W-1:0] head;
  logic [SRC_W-1:0] head_src;
  logic [DST_W-1:0] head_dst, wait_dst;
  logic [CW-1:0] cnt;
  assign {head_src, head_dst} = head;
  assign pop = !empty && state != WAIT_MDR;
  assign bus.cmd_ready = !full;
  assign bus.busy = count != '0 || state != IDLE;
  cmd_fifo #(.DEPTH(DEPTH), .W(SRC_W + DST_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.cmd_valid),
    .pop(pop),
    .din({bus.cmd_src, bus.cmd_dst}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // IDLE and DRIVE dispatch identically, giving one transfer per cycle back to back
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.src_out <= '0;
      bus.dst_in <= '0;
      bus.err <= 1'b0;
      cnt <= '0;
      wait_dst <= '0;
    end else begin
      bus.err <= 1'b0;
      bus.src_out <= '0;
      bus.dst_in <= '0;
      if (state == WAIT_MDR) begin
        cnt <= cnt + 1'b1;
        if (bus.mdr_valid) begin
          state <= DRIVE;
          bus.src_out <= onehot(SRC_MDR);
          bus.dst_in <= wait_dst;
        end else if (cnt == CW'(MDR_TMO - 1)) begin
          state <= IDLE;
          bus.err <= 1'b1;
        end
      end else if (!empty) begin
        if (head_src >= SRC_COUNT) begin
          state <= IDLE;
          bus.err <= 1'b1;
        end else if (head_src == SRC_MDR && !bus.mdr_valid) begin
          state <= WAIT_MDR;
          cnt <= '0;
          wait_dst <= head_dst;
        end else begin
          state <= DRIVE;
          bus.src_out <= onehot(head_src);
          bus.dst_in <= head_dst;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// tb_bus_xfer_sequencer: directed and random transfers against a queue-based timing model
module tb_bus_xfer_sequencer;
  localparam int MAXC = 20000;
  typedef struct {
    logic [4:0] src;
    logic [23:0] dst;
    int t;
  } cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit mdr_rand = 1'b0;
  bit mdr_set = 1'b1;
  bit mdr_hist [MAXC];
  cmd_t q[$];
  cmd_t c;
  int p, e_cyc, last_e;
  bit e_err;
  logic [22:0] e_src;
  logic [23:0] e_dst;

  bus_xfer_sequencer_if #(.DST_W(24)) bus ();
  bus_xfer_sequencer #(.DEPTH(4), .DST_W(24), .MDR_TMO(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    bus.mdr_valid = mdr_rand ? ($urandom_range(0, 9) < 7) : mdr_set;
  end

  task automatic chk(input bit ok, input string name, input string info);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, info);
  endtask

  // Expected timing: each entry occupies one dispatch slot after its push; an MDR entry
  // completes one cycle after the first mdr_valid seen in its 16-cycle window, else errors.
  always @(negedge clk) begin
    if (cyc < MAXC) mdr_hist[cyc] = bus.mdr_valid;
    if (rst) begin
      q.delete();
      last_e = 0;
    end else begin
      chk($onehot0(bus.src_out) && (bus.src_out != 0 || bus.dst_in == 0), "onehot",
          $sformatf("cycle %0d src_out=%h dst_in=%h", cyc, bus.src_out, bus.dst_in));
      if (bus.err || bus.src_out != 0) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected", $sformatf("cycle %0d err=%b src_out=%h dst_in=%h, expected nothing",
              cyc, bus.err, bus.src_out, bus.dst_in));
        end else begin
          c = q.pop_front();
          p = ((c.t + 2 > last_e + 1) ? c.t + 2 : last_e + 1) - 1;
          e_cyc = p + 1;
          e_err = 1'b0;
          e_src = '0;
          e_dst = '0;
          if (c.src > 22) e_err = 1'b1;
          else if (c.src == 21) begin
            e_cyc = p + 16;
            e_err = 1'b1;
            for (int k = 15; k >= 0; k--)
              if (p + k < MAXC && mdr_hist[p+k]) begin
                e_cyc = p + k + 1;
                e_err = 1'b0;
              end
          end
          if (!e_err) begin
            e_src = 23'(1) << c.src;
            e_dst = c.dst;
          end
          chk(bus.err == e_err && bus.src_out == e_src && bus.dst_in == e_dst && cyc == e_cyc, "xfer",
              $sformatf("src=%0d got err=%b src_out=%h dst_in=%h cycle %0d, expected err=%b src_out=%h dst_in=%h cycle %0d",
              c.src, bus.err, bus.src_out, bus.dst_in, cyc, e_err, e_src, e_dst, e_cyc));
          last_e = cyc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [4:0] s, input logic [23:0] d);
    cmd_t x;
    bus.cmd_valid = 1'b1;
    bus.cmd_src = s;
    bus.cmd_dst = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        x.src = s;
        x.dst = d;
        x.t = cyc;
        q.push_back(x);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk(1'b0, "send_timeout", $sformatf("src=%0d never accepted, cmd_ready=%b", s, bus.cmd_ready));
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q.size() != 0 || bus.busy) && i < 300) begin
      tick(1);
      i++;
    end
    chk(q.size() == 0 && !bus.busy, "drain",
        $sformatf("pending=%0d busy=%b, expected 0 and 0", q.size(), bus.busy));
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_src = '0;
    bus.cmd_dst = '0;
    tick(3);
    rst = 1'b0;
    chk(bus.src_out == 0 && bus.dst_in == 0 && !bus.busy && bus.cmd_ready && !bus.err, "reset_state",
        $sformatf("src_out=%h dst_in=%h busy=%b ready=%b err=%b", bus.src_out, bus.dst_in, bus.busy, bus.cmd_ready, bus.err));

    send(5'd3, 24'h000010);
    @(negedge clk);
    @(negedge clk);
    chk(bus.src_out == 23'h000008 && bus.dst_in == 24'h10 && bus.busy, "single_move",
        $sformatf("src_out=%h dst_in=%h busy=%b, expected 000008 000010 1", bus.src_out, bus.dst_in, bus.busy));
    @(negedge clk);
    chk(bus.src_out == 0 && !bus.busy, "single_release",
        $sformatf("src_out=%h busy=%b, expected 0 0", bus.src_out, bus.busy));
    drain();

    mdr_set = 1'b0;
    send(5'd21, 24'h000001);
    tick(2);
    send(5'd0, 24'h1);
    send(5'd1, 24'h2);
    send(5'd2, 24'h4);
    send(5'd20, 24'h8);
    bus.cmd_valid = 1'b1;
    bus.cmd_src = 5'd5;
    bus.cmd_dst = 24'h20;
    @(negedge clk);
    chk(!bus.cmd_ready, "full_ready", $sformatf("cmd_ready=%b with 4 queued, expected 0", bus.cmd_ready));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    mdr_set = 1'b1;
    send(5'd5, 24'h20);
    drain();

    mdr_set = 1'b0;
    send(5'd21, 24'h000080);
    tick(4);
    mdr_set = 1'b1;
    drain();

    mdr_set = 1'b0;
    send(5'd21, 24'h000100);
    send(5'd6, 24'h000200);
    tick(20);
    mdr_set = 1'b1;
    drain();

    send(5'd25, 24'hFFFFFF);
    send(5'd7, 24'h000003);
    send(5'd9, 24'h000000);
    drain();

    mdr_set = 1'b0;
    send(5'd21, 24'h1);
    send(5'd1, 24'h2);
    send(5'd2, 24'h4);
    rst = 1'b1;
    tick(1);
    chk(bus.src_out == 0 && bus.dst_in == 0 && !bus.busy && bus.cmd_ready, "mid_reset",
        $sformatf("src_out=%h dst_in=%h busy=%b ready=%b", bus.src_out, bus.dst_in, bus.busy, bus.cmd_ready));
    tick(1);
    rst = 1'b0;
    mdr_set = 1'b1;
    send(5'd4, 24'h5);
    drain();

    mdr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      send(($urandom_range(0, 9) == 0) ? 5'($urandom_range(23, 31)) : 5'($urandom_range(0, 22)), 24'($urandom));
    end
    mdr_rand = 1'b0;
    mdr_set = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
